// File: rtl/msx_wait_pkg.sv
// Shared types and helpers for the Z80 wait-state generator.
package msx_wait_pkg;

  // Bus cycle class, decided on the first CPU clock of each cycle
  typedef enum logic [2:0] {
    CYC_M1,
    CYC_MEM,
    CYC_IO,
    CYC_INTA,
    CYC_RFSH
  } cycle_t;

  // Wait generator state
  typedef enum logic [1:0] {
    W_IDLE,
    W_PROG,
    W_EXT,
    W_DONE
  } wstate_t;

  // Classifier result handed from the bus front-end to the FSM
  typedef struct packed {
    logic   start;
    cycle_t cycle;
    logic   bus_act;
  } cls_t;

  localparam int unsigned EXT_CH_MAX = 8;

  // Programmed wait count for a cycle class; INTA and refresh never wait
  function automatic int unsigned waits_for(input cycle_t cyc,
                                            input int unsigned m1_w,
                                            input int unsigned mem_w,
                                            input int unsigned io_w);
    int unsigned n;
    n = 0;
    case (cyc)
      CYC_M1:  n = m1_w;
      CYC_MEM: n = mem_w;
      CYC_IO:  n = io_w;
      default: n = 0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/msx_wait_gen_if.sv
// CPU bus, external wait requests and wait-generator status.
interface msx_wait_gen_if #(
  parameter int unsigned EXT_CH = 2
);
  logic              mreq_n;
  logic              iorq_n;
  logic              m1_n;
  logic              rfsh_n;
  logic              turbo;
  logic [EXT_CH-1:0] ext_wait_n;
  logic [EXT_CH-1:0] ext_en;
  logic              wait_n;
  logic              wait_active;
  logic              timeout_err;
  logic [EXT_CH-1:0] timeout_ch;

  // CPU / system side
  modport master (
    output mreq_n, iorq_n, m1_n, rfsh_n, turbo, ext_wait_n, ext_en,
    input  wait_n, wait_active, timeout_err, timeout_ch
  );

  // Wait generator side
  modport slave (
    input  mreq_n, iorq_n, m1_n, rfsh_n, turbo, ext_wait_n, ext_en,
    output wait_n, wait_active, timeout_err, timeout_ch
  );
endinterface

// File: rtl/msx_cycle_classify.sv
// Detects the start of each Z80 bus cycle and classifies it.
module msx_cycle_classify
  import msx_wait_pkg::*;
(
  input  logic clk21m,
  input  logic reset,
  input  logic i_ce,
  input  logic i_mreq_n,
  input  logic i_iorq_n,
  input  logic i_m1_n,
  input  logic i_rfsh_n,
  output cls_t o_cls_c
);

  logic   w_bus_act;
  logic   r_bus_act_q;
  cycle_t w_cycle;

  assign w_bus_act = ~i_mreq_n | ~i_iorq_n;

  // Previous sampled bus activity, for rising-edge detection on ce
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      r_bus_act_q <= 1'b0;
    end else if (i_ce) begin
      r_bus_act_q <= w_bus_act;
    end
  end

  // Priority classification: INTA, refresh, M1, I/O, then plain memory
  always_comb begin
    w_cycle = CYC_MEM;
    if (~i_iorq_n & ~i_m1_n) begin
      w_cycle = CYC_INTA;
    end else if (~i_rfsh_n) begin
      w_cycle = CYC_RFSH;
    end else if (~i_m1_n) begin
      w_cycle = CYC_M1;
    end else if (~i_iorq_n) begin
      w_cycle = CYC_IO;
    end
  end

  assign o_cls_c.start   = i_ce & w_bus_act & ~r_bus_act_q;
  assign o_cls_c.cycle   = w_cycle;
  assign o_cls_c.bus_act = w_bus_act;

endmodule

// File: rtl/msx_wait_gen.sv
// Z80 wait-state generator: per-class programmed waits plus watchdog-bounded
// external wait requests, evaluated on the 3.58 MHz CPU clock enable.
module msx_wait_gen
  import msx_wait_pkg::*;
#(
  parameter int unsigned M1_WAITS  = 1,
  parameter int unsigned MEM_WAITS = 0,
  parameter int unsigned IO_WAITS  = 1,
  parameter int unsigned EXT_CH    = 2,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_W     = 8
) (
  input  logic           clk21m,
  input  logic           reset,
  input  logic           ce_3m58_p,
  msx_wait_gen_if.slave  bus
);

  localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  // Elaboration-time parameter range checks
  if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
    $error("msx_wait_gen: CNT_W must be 1..31");
  end
  if (M1_WAITS > CNT_MAX || MEM_WAITS > CNT_MAX || IO_WAITS > CNT_MAX) begin : g_bad_waits
    $error("msx_wait_gen: wait parameters exceed counter range");
  end
  if (TIMEOUT < 1 || TIMEOUT > CNT_MAX) begin : g_bad_timeout
    $error("msx_wait_gen: TIMEOUT must be 1..2^CNT_W-1");
  end
  if (EXT_CH < 1 || EXT_CH > EXT_CH_MAX) begin : g_bad_ext_ch
    $error("msx_wait_gen: EXT_CH must be 1..8");
  end

  cls_t              w_cls;
  logic [EXT_CH-1:0] w_ext_vec;
  logic              w_ext;
  logic [CNT_W-1:0]  w_n;

  wstate_t           r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_wait_n;
  logic              r_wait_active;
  logic              r_timeout_err;
  logic [EXT_CH-1:0] r_timeout_ch;

  wstate_t           w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_wait_n_nxt;
  logic              w_wait_active_nxt;
  logic              w_timeout_err_nxt;
  logic [EXT_CH-1:0] w_timeout_ch_nxt;

  msx_cycle_classify u_classify (
    .clk21m   (clk21m),
    .reset    (reset),
    .i_ce     (ce_3m58_p),
    .i_mreq_n (bus.mreq_n),
    .i_iorq_n (bus.iorq_n),
    .i_m1_n   (bus.m1_n),
    .i_rfsh_n (bus.rfsh_n),
    .o_cls_c  (w_cls)
  );

  // Active, enabled external wait requests
  assign w_ext_vec = ~bus.ext_wait_n & bus.ext_en;
  assign w_ext     = |w_ext_vec;

  // Programmed wait count for the cycle being started; turbo drops it to zero
  assign w_n = bus.turbo ? '0
                         : CNT_W'(waits_for(w_cls.cycle, M1_WAITS, MEM_WAITS, IO_WAITS));

  // State, counter and output registers
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      r_state       <= W_IDLE;
      r_cnt         <= '0;
      r_wait_n      <= 1'b1;
      r_wait_active <= 1'b0;
      r_timeout_err <= 1'b0;
      r_timeout_ch  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_wait_n      <= w_wait_n_nxt;
      r_wait_active <= w_wait_active_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_timeout_ch  <= w_timeout_ch_nxt;
    end
  end

  // Next-state logic; bus end always wins over any other event in a wait
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_wait_n_nxt      = r_wait_n;
    w_timeout_err_nxt = 1'b0;
    w_timeout_ch_nxt  = r_timeout_ch;

    if (ce_3m58_p) begin
      case (r_state)
        W_IDLE: begin
          if (w_cls.start) begin
            if (w_n != '0) begin
              w_state_nxt  = W_PROG;
              w_wait_n_nxt = 1'b0;
              w_cnt_nxt    = w_n - CNT_W'(1);
            end else if (w_ext && (w_cls.cycle != CYC_RFSH)) begin
              w_state_nxt  = W_EXT;
              w_wait_n_nxt = 1'b0;
              w_cnt_nxt    = '0;
            end else begin
              w_state_nxt  = W_DONE;
              w_cnt_nxt    = '0;
            end
          end
        end

        W_PROG: begin
          if (!w_cls.bus_act) begin
            w_state_nxt  = W_IDLE;
            w_wait_n_nxt = 1'b1;
            w_cnt_nxt    = '0;
          end else if (r_cnt != '0) begin
            w_cnt_nxt    = r_cnt - CNT_W'(1);
          end else if (w_ext) begin
            w_state_nxt  = W_EXT;
            w_cnt_nxt    = '0;
          end else begin
            w_state_nxt  = W_DONE;
            w_wait_n_nxt = 1'b1;
          end
        end

        W_EXT: begin
          if (!w_cls.bus_act) begin
            w_state_nxt  = W_IDLE;
            w_wait_n_nxt = 1'b1;
            w_cnt_nxt    = '0;
          end else if (!w_ext) begin
            w_state_nxt  = W_DONE;
            w_wait_n_nxt = 1'b1;
            w_cnt_nxt    = '0;
          end else if (r_cnt == TO_LAST) begin
            w_state_nxt       = W_DONE;
            w_wait_n_nxt      = 1'b1;
            w_cnt_nxt         = '0;
            w_timeout_err_nxt = 1'b1;
            w_timeout_ch_nxt  = w_ext_vec;
          end else begin
            w_cnt_nxt    = r_cnt + CNT_W'(1);
          end
        end

        W_DONE: begin
          if (!w_cls.bus_act) begin
            w_state_nxt = W_IDLE;
          end
        end

        default: begin
          w_state_nxt  = W_IDLE;
          w_wait_n_nxt = 1'b1;
          w_cnt_nxt    = '0;
        end
      endcase
    end

    w_wait_active_nxt = (w_state_nxt == W_PROG) || (w_state_nxt == W_EXT);
  end

  assign bus.wait_n      = r_wait_n;
  assign bus.wait_active = r_wait_active;
  assign bus.timeout_err = r_timeout_err;
  assign bus.timeout_ch  = r_timeout_ch;

endmodule

// File: tb/tb_msx_wait_gen.sv
// Scoreboard bench: two generators (default and IO_WAITS=3/TIMEOUT=4) share
// one stimulus stream; a monitor measures each bus cycle and checks it.
module tb_msx_wait_gen;

  logic       clk21m = 1'b0;
  logic       reset  = 1'b1;
  logic       ce_3m58_p = 1'b0;
  int         ce_div = 0;

  logic       mreq_n = 1'b1;
  logic       iorq_n = 1'b1;
  logic       m1_n   = 1'b1;
  logic       rfsh_n = 1'b1;
  logic       turbo  = 1'b0;
  logic [1:0] ext_wait_n = 2'b11;
  logic [1:0] ext_en     = 2'b00;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pushed = 0;
  int n_seen   = 0;

  typedef struct {
    string      name;
    int         low0;
    int         low1;
    int         terr0;
    int         terr1;
    logic [1:0] tch0;
    logic [1:0] tch1;
  } exp_t;

  exp_t exp_q[$];

  msx_wait_gen_if #(.EXT_CH(2)) bus0 ();
  msx_wait_gen_if #(.EXT_CH(2)) bus1 ();

  assign bus0.mreq_n = mreq_n;      assign bus1.mreq_n = mreq_n;
  assign bus0.iorq_n = iorq_n;      assign bus1.iorq_n = iorq_n;
  assign bus0.m1_n   = m1_n;        assign bus1.m1_n   = m1_n;
  assign bus0.rfsh_n = rfsh_n;      assign bus1.rfsh_n = rfsh_n;
  assign bus0.turbo  = turbo;       assign bus1.turbo  = turbo;
  assign bus0.ext_wait_n = ext_wait_n; assign bus1.ext_wait_n = ext_wait_n;
  assign bus0.ext_en = ext_en;      assign bus1.ext_en = ext_en;

  msx_wait_gen #(.EXT_CH(2)) dut0 (
    .clk21m    (clk21m),
    .reset     (reset),
    .ce_3m58_p (ce_3m58_p),
    .bus       (bus0)
  );

  msx_wait_gen #(.IO_WAITS(3), .TIMEOUT(4), .EXT_CH(2)) dut1 (
    .clk21m    (clk21m),
    .reset     (reset),
    .ce_3m58_p (ce_3m58_p),
    .bus       (bus1)
  );

  always #5 clk21m = ~clk21m;

  // CPU clock enable: one clk21m in six
  always @(negedge clk21m) begin
    ce_div    = (ce_div == 5) ? 0 : ce_div + 1;
    ce_3m58_p = (ce_div == 0);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Monitor: measures each bus cycle and compares against the queue head
  logic prev_act = 1'b0;
  bit   in_cyc   = 1'b0;
  int   low0, low1, terr0, terr1;
  always @(posedge clk21m) begin
    bit   ce_s;
    bit   act;
    exp_t e;
    ce_s = ce_3m58_p;
    #1;
    if (reset) begin
      in_cyc   = 1'b0;
      prev_act = 1'b0;
    end else begin
      if (in_cyc) begin
        terr0 += int'(bus0.timeout_err);
        terr1 += int'(bus1.timeout_err);
      end
      if (ce_s) begin
        act = !mreq_n || !iorq_n;
        if (act && !prev_act) begin
          in_cyc = 1'b1;
          low0 = 0; low1 = 0; terr0 = 0; terr1 = 0;
        end
        if (in_cyc) begin
          low0 += int'(!bus0.wait_n);
          low1 += int'(!bus1.wait_n);
          check("wait_active0", int'(bus0.wait_active), int'(!bus0.wait_n));
          check("wait_active1", int'(bus1.wait_active), int'(!bus1.wait_n));
        end
        if (!act && prev_act && in_cyc) begin
          in_cyc = 1'b0;
          n_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_cycle", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check({e.name, ".low0"},  low0,  e.low0);
            check({e.name, ".low1"},  low1,  e.low1);
            check({e.name, ".terr0"}, terr0, e.terr0);
            check({e.name, ".terr1"}, terr1, e.terr1);
            check({e.name, ".tch0"},  int'(bus0.timeout_ch), int'(e.tch0));
            check({e.name, ".tch1"},  int'(bus1.timeout_ch), int'(e.tch1));
          end
        end
        prev_act = act;
      end
    end
  end

  task automatic wait_ce();
    @(posedge clk21m iff ce_3m58_p);
    @(negedge clk21m);
  endtask

  // One bus cycle held for len ce edges; ext requests held for ext_len edges
  task automatic run_cycle(input string nm,
                           input logic mq, input logic iq, input logic m1,
                           input logic rf, input logic tb,
                           input logic [1:0] pull, input logic [1:0] en,
                           input int len, input int ext_len,
                           input int l0, input int l1,
                           input int t0, input int t1,
                           input logic [1:0] c0, input logic [1:0] c1);
    exp_t e;
    e.name = nm; e.low0 = l0; e.low1 = l1; e.terr0 = t0; e.terr1 = t1;
    e.tch0 = c0; e.tch1 = c1;
    exp_q.push_back(e);
    n_pushed++;
    mreq_n = mq; iorq_n = iq; m1_n = m1; rfsh_n = rf; turbo = tb;
    ext_en = en;
    ext_wait_n = (ext_len > 0) ? ~pull : 2'b11;
    for (int i = 0; i < len; i++) begin
      wait_ce();
      if (i + 1 == ext_len) ext_wait_n = 2'b11;
    end
    mreq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
    turbo = 1'b0; ext_wait_n = 2'b11; ext_en = 2'b00;
    wait_ce();
    wait_ce();
  endtask

  initial begin
    repeat (4) @(negedge clk21m);
    check("rst.wait_n0",      int'(bus0.wait_n),      1);
    check("rst.wait_n1",      int'(bus1.wait_n),      1);
    check("rst.wait_active0", int'(bus0.wait_active), 0);
    check("rst.timeout_err1", int'(bus1.timeout_err), 0);
    check("rst.timeout_ch1",  int'(bus1.timeout_ch),  0);
    reset = 1'b0;
    wait_ce();
    wait_ce();

    //        name              mq iq m1 rf tb pull   en    len ext  l0 l1 t0 t1 tch0   tch1
    run_cycle("m1_fetch",        0, 1, 0, 1, 0, 2'b00, 2'b00, 4, 0,  1, 1, 0, 0, 2'b00, 2'b00);
    run_cycle("io_out",          1, 0, 1, 1, 0, 2'b00, 2'b00, 6, 0,  1, 3, 0, 0, 2'b00, 2'b00);
    run_cycle("io_turbo",        1, 0, 1, 1, 1, 2'b00, 2'b00, 6, 0,  0, 0, 0, 0, 2'b00, 2'b00);
    run_cycle("ext_ch1_5",       0, 1, 1, 1, 0, 2'b10, 2'b10, 8, 5,  5, 4, 0, 1, 2'b00, 2'b10);
    run_cycle("ext_ch1_off",     0, 1, 1, 1, 0, 2'b10, 2'b00, 8, 5,  0, 0, 0, 0, 2'b00, 2'b10);
    run_cycle("ext_ch0_stuck",   0, 1, 1, 1, 0, 2'b01, 2'b01, 8, 8,  8, 4, 0, 1, 2'b00, 2'b01);
    run_cycle("refresh_ext",     0, 1, 1, 0, 0, 2'b11, 2'b11, 4, 4,  0, 0, 0, 0, 2'b00, 2'b01);
    run_cycle("inta",            1, 0, 0, 1, 0, 2'b00, 2'b00, 4, 0,  0, 0, 0, 0, 2'b00, 2'b01);
    run_cycle("io_early_end",    1, 0, 1, 1, 0, 2'b00, 2'b00, 2, 0,  1, 2, 0, 0, 2'b00, 2'b01);
    run_cycle("abort_vs_tmo",    0, 1, 1, 1, 0, 2'b01, 2'b01, 4, 4,  4, 4, 0, 0, 2'b00, 2'b01);
    run_cycle("mem_nowait",      0, 1, 1, 1, 0, 2'b00, 2'b00, 3, 0,  0, 0, 0, 0, 2'b00, 2'b01);

    // Reset while dut1 sits in PROG with counter=2
    mreq_n = 1'b1; iorq_n = 1'b0; m1_n = 1'b1; rfsh_n = 1'b1;
    wait_ce();
    check("pre_reset.wait_n1", int'(bus1.wait_n), 0);
    reset = 1'b1;
    #1;
    check("mid_reset.wait_n0",      int'(bus0.wait_n),      1);
    check("mid_reset.wait_n1",      int'(bus1.wait_n),      1);
    check("mid_reset.wait_active1", int'(bus1.wait_active), 0);
    check("mid_reset.timeout_ch1",  int'(bus1.timeout_ch),  0);
    iorq_n = 1'b1;
    repeat (3) @(negedge clk21m);
    reset = 1'b0;
    wait_ce();

    run_cycle("m1_after_reset",  0, 1, 0, 1, 0, 2'b00, 2'b00, 4, 0,  1, 1, 0, 0, 2'b00, 2'b00);

    wait_ce();
    check("queue_drained", exp_q.size(), 0);
    check("cycles_seen",   n_seen, n_pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msx_wait_gen.md
Name: msx_wait_gen

Overview:
- Parametrised Z80 wait-state generator for the MSX core; replaces the fixed M1-only two-flop wait logic in the top level.
- Classifies each CPU bus cycle (M1 fetch, memory, I/O, refresh, interrupt acknowledge) and drives wait_n low for a per-class programmed number of CPU clocks.
- Also extends the wait while any enabled external device holds its wait request, bounded by a timeout watchdog.
- Sits between the CPU bus signals and the CPU wait_n input; sampled on the 3.58 MHz CPU clock enable.

Parameters:
M1_WAITS, 1, wait states added to opcode fetch (1 = standard MSX behaviour)
MEM_WAITS, 0, wait states added to non-M1 memory read/write
IO_WAITS, 1, wait states added to I/O read/write
EXT_CH, 2, number of external wait-request channels (1..8)
TIMEOUT, 255, maximum CPU clocks an external wait may extend a cycle (1..2^CNT_W-1)
CNT_W, 8, width of the wait/timeout counter

Ports:
clk21m  in  1  system clock 21.48 MHz
reset  in  1  asynchronous, active-high
ce_3m58_p  in  1  CPU clock enable (rising phase); all state changes except reset occur only on clk21m edges with ce_3m58_p=1
mreq_n  in  1  CPU memory request
iorq_n  in  1  CPU I/O request
m1_n  in  1  CPU M1
rfsh_n  in  1  CPU refresh
turbo  in  1  1 = programmed waits forced to 0; external waits still honoured
ext_wait_n  in  EXT_CH  per-device wait request, active-low
ext_en  in  EXT_CH  per-channel enable; disabled channels are ignored
wait_n  out  1  to CPU WAIT_n, registered
wait_active  out  1  1 while in PROG or EXT state
timeout_err  out  1  one-clk21m pulse when the watchdog forces release
timeout_ch  out  EXT_CH  sticky mask of channels active at the last timeout; cleared only by reset

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk21m. On reset: wait_n=1, wait_active=0, timeout_err=0, timeout_ch=0, state=IDLE, counter=0. Reset mid-wait releases the CPU immediately.
- Cycle start: bus_act = ~mreq_n | ~iorq_n, sampled on ce; a start is bus_act=1 on a ce where the previous sampled bus_act was 0.
- Classification at start, first match wins:
  - ~iorq_n & ~m1_n: INTA, 0 programmed waits.
  - ~rfsh_n: REFRESH, 0 programmed waits, external waits ignored.
  - ~m1_n: M1, M1_WAITS.
  - ~iorq_n: IO, IO_WAITS.
  - otherwise: MEM, MEM_WAITS.
- turbo=1 sampled at start: programmed count n=0.
- Let ext = |(~ext_wait_n & ext_en).
- State IDLE, on start:
  - If n>0: go to PROG, wait_n<=0, counter<=n-1.
  - Else if ext: go to EXT, wait_n<=0, counter<=0.
  - Else: go to DONE, wait_n stays 1.
- State PROG, each ce:
  - If counter!=0: counter decrements.
  - Else if ext: go to EXT, counter<=0.
  - Else: go to DONE, wait_n<=1.
- Wait duration: wait_n is low for exactly n ce periods. With M1_WAITS=1 this gives one wait in M1, matching legacy timing: low at the T1 ce, high at the following ce.
- State EXT, each ce:
  - If ~ext: go to DONE, wait_n<=1.
  - Else if counter==TIMEOUT-1: go to DONE, wait_n<=1, timeout_err pulses, timeout_ch<=(~ext_wait_n & ext_en).
  - Else: counter increments.
- State DONE: on a ce with bus_act=0, go to IDLE. A new external request inside DONE is ignored.
- Early end: bus_act=0 sampled in PROG or EXT aborts to IDLE with wait_n<=1 and no timeout_err.
- Simultaneous events: cycle end and timeout on the same ce means the abort wins and no pulse is produced.
- Counter arithmetic is unsigned CNT_W bits with no wrap. Parameter values above 2^CNT_W-1 are an elaboration error, raised via an assertion.
- wait_active = (state==PROG)|(state==EXT), registered alongside wait_n.

Decomposition:
- Package msx_wait_pkg holds:
  - typedef enum cycle_t {CYC_M1, CYC_MEM, CYC_IO, CYC_INTA, CYC_RFSH}
  - typedef enum wstate_t {W_IDLE, W_PROG, W_EXT, W_DONE}
  - function waits_for(cycle_t).
- One sub-module, msx_cycle_classify: bus_act edge detection plus combinational classification, outputting start and cycle_t. The FSM and counter stay in msx_wait_gen.

Test Plan:
- Default params, M1 fetch (m1_n, mreq_n low at ce k) → wait_n=0 at ce k, wait_n=1 at ce k+1; exactly one low ce period; no other outputs change.
- IO_WAITS=3, OUT cycle → wait_n low for exactly 3 ce periods. With turbo=1 the same cycle gives 0 ce periods low.
- MEM_WAITS=0, ext_wait_n[1]=0 with ext_en=2'b10, held for 5 ce periods → wait_n low 5 ce periods. Repeat with ext_en=2'b00 → no wait.
- TIMEOUT=4, ext_wait_n[0] stuck low → wait_n released after 4 ce periods; timeout_err high for one clk21m; timeout_ch=2'b01, which persists after ext_wait_n returns high.
- Refresh cycle (rfsh_n=0, mreq_n=0) with ext_wait_n=0 → wait_n stays 1. INTA cycle with default params → wait_n stays 1.
- Assert reset while in PROG with counter=2 → wait_n=1 asynchronously, state IDLE; next M1 cycle after release behaves as in scenario 1.
